// File: rtl/sky130_ajc_ip__ovmon_ctrl.sv
// Over-voltage monitor controller: per-channel settle/debounce FSM; optional sticky flags via OVMON_STICKY_EN.
// Latency: comp_in edge to ovout change = 2 (sync) + db_len + 2 cycles; irq one cycle after its source.
// Backpressure: none; the block is free-running and consumes comp_in every cycle.
module sky130_ajc_ip__ovmon_ctrl #(
    parameter int NCH    = 4,
    parameter int TRIPW  = 4,
    parameter int DBW    = 8,
    parameter int SETTLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       ena,
    input  logic [NCH*TRIPW-1:0] otrip_cfg,
    input  logic [NCH-1:0]       comp_in,
    input  logic [DBW-1:0]       db_len,
    input  logic [NCH-1:0]       clr,
    input  logic [NCH-1:0]       irq_mask,
    output logic [NCH-1:0]       ena_ana,
    output logic [NCH*TRIPW-1:0] otrip,
    output logic [NCH-1:0]       ovout,
    output logic [NCH-1:0]       ov_sticky,
    output logic                 irq
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_SETTLE,
        ST_LOW,
        ST_RISE,
        ST_HIGH,
        ST_FALL
    } state_t;

    logic [NCH-1:0] sync_a;
    logic [NCH-1:0] sync_b;
    logic [NCH-1:0] ov_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= comp_in;
            sync_b <= sync_a;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [DBW-1:0]   cnt;
        logic [DBW-1:0]   cnt_nxt;
        logic [DBW-1:0]   dbl;
        logic [DBW-1:0]   dbl_nxt;
        logic [SW-1:0]    scnt;
        logic [SW-1:0]    scnt_nxt;
        logic [TRIPW-1:0] trip_q;
        logic             ena_q;
        logic             ov_q;

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            dbl_nxt   = dbl;
            scnt_nxt  = scnt;
            if (!ena[i]) begin
                state_nxt = ST_OFF;
                cnt_nxt   = '0;
                scnt_nxt  = '0;
            end else begin
                case (state)
                    ST_OFF: begin
                        state_nxt = ST_SETTLE;
                        scnt_nxt  = SETTLE_LOAD;
                    end
                    ST_SETTLE: begin
                        if (scnt == '0) state_nxt = ST_LOW;
                        else            scnt_nxt  = scnt - 1'b1;
                    end
                    ST_LOW: begin
                        if (sync_b[i]) begin
                            state_nxt = ST_RISE;
                            cnt_nxt   = '0;
                            dbl_nxt   = db_len;
                        end
                    end
                    ST_RISE: begin
                        if (!sync_b[i]) begin
                            state_nxt = ST_LOW;
                            cnt_nxt   = '0;
                        end else if (cnt == dbl) begin
                            state_nxt = ST_HIGH;
                        end else if (!(&cnt)) begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (!sync_b[i]) begin
                            state_nxt = ST_FALL;
                            cnt_nxt   = '0;
                            dbl_nxt   = db_len;
                        end
                    end
                    ST_FALL: begin
                        if (sync_b[i]) begin
                            state_nxt = ST_HIGH;
                        end else if (cnt == dbl) begin
                            state_nxt = ST_LOW;
                            cnt_nxt   = '0;
                        end else if (!(&cnt)) begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                    default: begin
                        state_nxt = ST_OFF;
                        cnt_nxt   = '0;
                        scnt_nxt  = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state  <= ST_OFF;
                cnt    <= '0;
                dbl    <= '0;
                scnt   <= '0;
                trip_q <= '0;
                ena_q  <= 1'b0;
                ov_q   <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                dbl   <= dbl_nxt;
                scnt  <= scnt_nxt;
                ena_q <= (state_nxt != ST_OFF);
                ov_q  <= ov_nxt[i];
                // Trip code is only retargeted while the comparator is powered down.
                if (state == ST_OFF) trip_q <= otrip_cfg[i*TRIPW +: TRIPW];
            end
        end

        assign ov_nxt[i]                = (state_nxt == ST_HIGH) || (state_nxt == ST_FALL);
        assign ena_ana[i]               = ena_q;
        assign ovout[i]                 = ov_q;
        assign otrip[i*TRIPW +: TRIPW]  = trip_q;
    end

`ifdef OVMON_STICKY_EN
    logic [NCH-1:0] sticky_q;

    // A new trip in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
            irq      <= 1'b0;
        end else begin
            sticky_q <= (ov_nxt & ~ovout) | (sticky_q & ~clr);
            irq      <= |(sticky_q & ~irq_mask);
        end
    end

    assign ov_sticky = sticky_q;
`else
    logic unused_inputs;
    assign unused_inputs = ^{clr, ov_nxt};

    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= |(ovout & ~irq_mask);
    end

    assign ov_sticky = '0;
`endif

endmodule

// File: tb/tb_sky130_ajc_ip__ovmon_ctrl.sv
// Directed bench for sky130_ajc_ip__ovmon_ctrl: debounce table plus settle, otrip, reset and sticky/irq sequences.
module tb_sky130_ajc_ip__ovmon_ctrl;
    localparam int NCH = 4, TRIPW = 4, DBW = 8, SETTLE = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       ena;
    logic [NCH*TRIPW-1:0] otrip_cfg;
    logic [NCH-1:0]       comp_in;
    logic [DBW-1:0]       db_len;
    logic [NCH-1:0]       clr;
    logic [NCH-1:0]       irq_mask;
    logic [NCH-1:0]       ena_ana;
    logic [NCH*TRIPW-1:0] otrip;
    logic [NCH-1:0]       ovout;
    logic [NCH-1:0]       ov_sticky;
    logic                 irq;

    always #5 clk = ~clk;

    sky130_ajc_ip__ovmon_ctrl #(.NCH(NCH), .TRIPW(TRIPW), .DBW(DBW), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .ena(ena), .otrip_cfg(otrip_cfg), .comp_in(comp_in),
        .db_len(db_len), .clr(clr), .irq_mask(irq_mask), .ena_ana(ena_ana),
        .otrip(otrip), .ovout(ovout), .ov_sticky(ov_sticky), .irq(irq)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [DBW-1:0] db;
        int             hi;
        int             lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ov(input int ch, input logic val, input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if (ovout[ch] === val) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int   lat;
        logic bad;

        // db_len, cycles comp_in held high, expected rise latency (0 = no trip)
        vecs[0] = '{8'd5, 3,  0};
        vecs[1] = '{8'd5, 6,  0};
        vecs[2] = '{8'd5, 7,  9};
        vecs[3] = '{8'd5, 40, 9};
        vecs[4] = '{8'd0, 1,  0};
        vecs[5] = '{8'd0, 2,  4};
        vecs[6] = '{8'd1, 3,  5};
        vecs[7] = '{8'd3, 40, 7};

        rst = 1'b1; ena = '0; otrip_cfg = 16'h3210; comp_in = '0;
        db_len = 8'd5; clr = '0; irq_mask = '0;
        step(3);
        check("rst_ena_ana", ena_ana, 0);
        check("rst_otrip", otrip, 0);
        check("rst_ovout", ovout, 0);
        check("rst_sticky", ov_sticky, 0);
        check("rst_irq", irq, 0);
        rst = 1'b0;
        step(1);
        check("otrip_load_off", otrip, 32'h3210);
        check("ena_ana_idle", ena_ana, 0);

        // Comparator high throughout the settle window must be ignored.
        ena = 4'b0001;
        comp_in[0] = 1'b1;
        step(1);
        check("ena_ana_next", ena_ana, 32'h1);
        bad = ovout[0];
        repeat (15) begin
            step(1);
            bad |= ovout[0];
        end
        check("settle_ignore", bad, 0);
        comp_in[0] = 1'b0;
        step(20);
        check("settle_no_trip", ovout[0], 0);

        for (int v = 0; v < 8; v++) begin
            db_len = vecs[v].db;
            comp_in[0] = 1'b1;
            lat = 0;
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk);
                #1;
                if (ovout[0] && lat == 0) lat = c;
                if (c == vecs[v].hi) comp_in[0] = 1'b0;
            end
            comp_in[0] = 1'b0;
            check($sformatf("vec%0d_rise_lat", v), lat, vecs[v].lat);
            step(30);
            check($sformatf("vec%0d_rest", v), ovout[0], 0);
        end

        db_len = 8'd5;
        comp_in[0] = 1'b1;
        wait_ov(0, 1'b1, 40, lat);
        check("ch0_rise_lat", lat, 9);
        step(1);
        check("ch0_irq_set", irq, 1);
        comp_in[0] = 1'b0;
        wait_ov(0, 1'b0, 40, lat);
        check("ch0_fall_lat", lat, 9);
        step(1);
`ifdef OVMON_STICKY_EN
        check("ch0_irq_sticky", irq, 1);
        check("ch0_sticky", ov_sticky[0], 1);
`else
        check("ch0_irq_clear", irq, 0);
`endif
        clr = 4'b0001;
        step(1);
        clr = '0;
        step(2);
        check("ch0_irq_idle", irq, 0);

        // Channel 1: trip code frozen outside OFF.
        ena[1] = 1'b1;
        step(1);
        check("ch1_otrip_init", otrip[7:4], 32'h1);
        step(17);
        comp_in[1] = 1'b1;
        wait_ov(1, 1'b1, 40, lat);
        check("ch1_rise_lat", lat, 9);
        otrip_cfg[7:4] = 4'b1010;
        step(3);
        check("ch1_otrip_hold", otrip[7:4], 32'h1);
        ena[1] = 1'b0;
        step(1);
        check("ch1_off_ovout", ovout[1], 0);
        check("ch1_off_ena_ana", ena_ana[1], 0);
        check("ch1_off_otrip", otrip[7:4], 32'h1);
        ena[1] = 1'b1;
        step(1);
        check("ch1_otrip_new", otrip[7:4], 32'hA);
        check("ch1_ena_ana_on", ena_ana[1], 1);
        comp_in[1] = 1'b0;
        step(20);
        clr = 4'b0010;
        step(1);
        clr = '0;
        step(2);

        // Channel 3: reset in the middle of RISE.
        ena[3] = 1'b1;
        step(17);
        comp_in[3] = 1'b1;
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_mid_ena_ana", ena_ana, 0);
        check("rst_mid_otrip", otrip, 0);
        check("rst_mid_ovout", ovout, 0);
        check("rst_mid_sticky", ov_sticky, 0);
        check("rst_mid_irq", irq, 0);
        comp_in[3] = 1'b0;
        bad = 1'b0;
        repeat (12) begin
            step(1);
            bad |= (|ovout) | (|ov_sticky);
        end
        check("rst_mid_quiet", bad, 0);

        // Channel 2: sticky flag and interrupt.
        ena = 4'b1111;
        step(18);
        comp_in[2] = 1'b1;
        wait_ov(2, 1'b1, 40, lat);
        check("ch2_rise_lat", lat, 9);
        comp_in[2] = 1'b0;
        wait_ov(2, 1'b0, 40, lat);
        check("ch2_fall_lat", lat, 9);
        step(1);
`ifdef OVMON_STICKY_EN
        check("ch2_sticky_set", ov_sticky[2], 1);
        check("ch2_irq_sticky", irq, 1);
        clr[2] = 1'b1;
        step(1);
        clr = '0;
        check("ch2_sticky_clr", ov_sticky[2], 0);
        step(1);
        check("ch2_irq_clr", irq, 0);
        comp_in[2] = 1'b1;
        step(8);
        clr[2] = 1'b1;
        step(1);
        clr = '0;
        check("ch2_retrip_ovout", ovout[2], 1);
        check("ch2_set_wins", ov_sticky[2], 1);
        step(1);
        check("ch2_sticky_keep", ov_sticky[2], 1);
        check("ch2_irq_retrip", irq, 1);
        irq_mask[2] = 1'b1;
        step(1);
        check("ch2_irq_masked", irq, 0);
`else
        check("ch2_sticky_tied", ov_sticky, 0);
        check("ch2_irq_follow", irq, 0);
        comp_in[2] = 1'b1;
        wait_ov(2, 1'b1, 40, lat);
        check("ch2_retrip_lat", lat, 9);
        step(1);
        check("ch2_irq_set", irq, 1);
        clr = 4'b0100;
        step(1);
        clr = '0;
        check("ch2_clr_ignored", ov_sticky, 0);
        check("ch2_ovout_hold", ovout[2], 1);
        irq_mask[2] = 1'b1;
        step(1);
        check("ch2_irq_masked", irq, 0);
`endif
        comp_in = '0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
